// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic handshaked pipeline stage register placed between two processor
// stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The payload is split into a control
// field and a data field. The stage provides valid/ready flow control,
// synchronous flush (bubble insertion) and a saturating stall counter.
//
// Optional feature macro: PIPE_SKID_EN
//   defined   : adds a one-entry skid register, so the stage holds 2 entries
//               and in_ready is registered (no combinational path from
//               out_ready).
//   undefined : one entry only, and in_ready = !main_v || out_ready.
//
// Parameters
//   DATA_W  data payload width (ALUResult + WriteData + PCPlus4 + Rd)
//   CTRL_W  control payload width (RegWrite, MemWrite, ResultSrc[1:0])
//   CNT_W   stall counter width
//
// Ports
//   clk        in   1       clock, all state updates on posedge
//   rst        in   1       synchronous active-high reset
//   flush      in   1       discard all held entries at this edge
//   in_valid   in   1       upstream presents a transaction
//   in_ready   out  1       stage accepts a transaction this cycle
//   in_ctrl    in   CTRL_W  upstream control field
//   in_data    in   DATA_W  upstream data field
//   out_valid  out  1       stage holds a transaction for downstream
//   out_ready  in   1       downstream accepts this cycle
//   out_ctrl   out  CTRL_W  control field, forced to 0 when out_valid=0
//   out_data   out  DATA_W  data field, stale when out_valid=0
//   stall_cnt  out  CNT_W   saturating count of out_valid && !out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic              main_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    logic accept;
    logic main_free;

    // Main can take a new value when it is empty or being handed downstream.
    assign main_free = !main_v || out_ready;
    assign accept    = in_valid && in_ready;

`ifdef PIPE_SKID_EN
    logic              skid_v;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Registered ready: the skid entry absorbs the one transaction that may
    // arrive in the cycle downstream stalls.
    assign in_ready = !skid_v;

    // ---- stage boundary: input -> main / skid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
        end else begin
            if (main_free) begin
                if (skid_v) begin
                    // Older skid entry goes first to keep acceptance order.
                    main_v    <= 1'b1;
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                    skid_v    <= 1'b0;
                end else if (accept) begin
                    main_v    <= 1'b1;
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end else begin
                    main_v    <= 1'b0;
                end
            end else if (accept) begin
                skid_v <= 1'b1;
            end
            // Flush kills validity only; payload registers keep stale values.
            if (flush) begin
                main_v <= 1'b0;
                skid_v <= 1'b0;
            end
        end
    end

    // Skid payload is qualified by skid_v, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!main_free && accept) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end
`else
    // Single entry: a slot frees up in the same cycle downstream takes main.
    assign in_ready = main_free;

    // ---- stage boundary: input -> main ----
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
        end else begin
            if (main_free) begin
                main_v <= accept;
                if (accept) begin
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end
            end
            if (flush) begin
                main_v <= 1'b0;
            end
        end
    end
`endif

    // Stall counter: only rst clears it; flush cycles still count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // ---- stage boundary: main -> downstream ----
    assign out_valid = main_v;
    // A bubble must never assert RegWrite/MemWrite downstream.
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. A scoreboard queue receives every
// accepted transaction and is popped on each delivery; per-scenario tasks add
// their own inline checks of latency, ready, bubble gating and the counter.
// Works for both builds (PIPE_SKID_EN defined or not).
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 101;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } item_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    item_t q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: at each negedge, pop on delivery, then push on acceptance
    // (or discard everything on flush/rst).
    task automatic scoreboard_monitor();
        item_t exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
            end else begin
                vectors++;
                if (out_valid !== (q.size() != 0)) begin
                    miscompares++;
                    $display("FAIL occupancy: out_valid=%b expected=%b (held=%0d)",
                             out_valid, (q.size() != 0), q.size());
                end
                if (out_valid === 1'b1 && out_ready === 1'b1 && q.size() != 0) begin
                    exp = q.pop_front();
                    vectors++;
                    if ({out_ctrl, out_data} !== {exp.ctrl, exp.data}) begin
                        miscompares++;
                        $display("FAIL delivery: got ctrl=%h data=%h expected ctrl=%h data=%h",
                                 out_ctrl, out_data, exp.ctrl, exp.data);
                    end
                end
                if (flush) begin
                    q.delete();
                end else if (in_valid && in_ready) begin
                    q.push_back(item_t'{ctrl: in_ctrl, data: in_data});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'hF;
        in_data   = DATA_W'(123);
        out_ready = 1'b0;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (out_ctrl !== '0) begin
            miscompares++;
            $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl);
        end
        vectors++;
        if (out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        vectors++;
        if (stall_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CTRL_W'(i);
            in_data  = DATA_W'(i);
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin
                miscompares++;
                $display("FAIL stream_%0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, out_valid, out_data, i);
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        item_t items[3];
        int    idx;
        logic  acc;
        logic  exp_rdy;
        items[0] = item_t'{ctrl: 4'h1, data: DATA_W'(32'hA)};
        items[1] = item_t'{ctrl: 4'h2, data: DATA_W'(32'hB)};
        items[2] = item_t'{ctrl: 4'h3, data: DATA_W'(32'hC)};
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            out_ready = (c >= 4);
            in_valid  = (idx < 3);
            in_ctrl   = items[(idx < 3) ? idx : 2].ctrl;
            in_data   = items[(idx < 3) ? idx : 2].data;
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                // Skid: B lands in skid at c=1, then ready stays low until B
                // moves to main. Single entry: ready returns when A leaves.
                exp_rdy = SKID ? (c == 1) : (c == 4);
                vectors++;
                if (in_ready !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL bp_in_ready_c%0d: got %b expected %b", c, in_ready, exp_rdy);
                end
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        vectors++;
        if (idx != 3) begin
            miscompares++;
            $display("FAIL bp_accepted: got %0d expected 3", idx);
        end
        vectors++;
        if (stall_cnt !== CNT_W'(3)) begin
            miscompares++;
            $display("FAIL bp_stall_cnt: got %0d expected 3", stall_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'b1101;
        in_data   = DATA_W'(32'hABC);
        step();
        flush   = 1'b1;
        in_ctrl = 4'hF;
        in_data = DATA_W'(32'hD);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            miscompares++;
            $display("FAIL flush_bubble: got valid=%b ctrl=%h expected valid=0 ctrl=0",
                     out_valid, out_ctrl);
        end
        vectors++;
        if (stall_cnt !== CNT_W'(4)) begin
            miscompares++;
            $display("FAIL flush_stall_cnt: got %0d expected 4", stall_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_d_%0d: got out_valid=%b data=%h expected 0",
                         i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 4'hF;
        in_data   = DATA_W'(7);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_ctrl !== 4'hF) begin
            miscompares++;
            $display("FAIL bubble_load: got valid=%b ctrl=%h expected valid=1 ctrl=f",
                     out_valid, out_ctrl);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_ready = (i < 2);
            step();
            vectors++;
            if (out_valid !== 1'b0 || out_ctrl !== '0) begin
                miscompares++;
                $display("FAIL bubble_gate_%0d: got valid=%b ctrl=%h expected valid=0 ctrl=0",
                         i, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h2;
        in_data   = DATA_W'(32'h55);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_cnt = (k > 15) ? 15 : k;
            vectors++;
            if (stall_cnt !== CNT_W'(exp_cnt)) begin
                miscompares++;
                $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, stall_cnt, exp_cnt);
            end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if (stall_cnt !== CNT_W'(15) || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_after_flush: got cnt=%0d valid=%b expected cnt=15 valid=0",
                     stall_cnt, out_valid);
        end
        out_ready = 1'b1;
        step();
        step();
        vectors++;
        if (stall_cnt !== CNT_W'(15)) begin
            miscompares++;
            $display("FAIL sat_hold: got %0d expected 15", stall_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (stall_cnt !== '0) begin
            miscompares++;
            $display("FAIL sat_rst_clear: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ctrl   = CTRL_W'($urandom());
            in_data   = {$urandom(), $urandom(), $urandom(), 5'($urandom())};
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: got out_valid=%b left=%0d expected 0/0", out_valid, q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register. It is the generic successor to the fixed EX/MEM buffer and is instantiated between any two processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Payload is split into a control field and a data field, with valid/ready flow control (stall), synchronous flush (bubble insertion) and a saturating stall counter. An optional skid entry breaks the combinational ready path.

## Interface
Parameters:
- DATA_W, 101: data payload width (default = ALUResult 32 + WriteData 32 + PCPlus4 32 + Rd 5).
- CTRL_W, 4: control payload width (default = RegWrite, MemWrite, ResultSrc[1:0]).
- CNT_W, 16: stall counter width.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held entries this edge.
- in_valid  in  1  upstream presents a transaction.
- in_ready  out  1  stage accepts a transaction this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  stage holds a transaction for downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control field, forced 0 when out_valid=0.
- out_data  out  DATA_W  data field, don't-care when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- Main entry (main_v, main_ctrl, main_data) drives the outputs. out_ctrl = main_v ? main_ctrl : 0, so a bubble never asserts RegWrite or MemWrite downstream.
- Transactions leave in acceptance order. None are dropped except by flush or rst, and none are duplicated.
- Main entry loads when it is empty or being delivered and a transaction is available, from skid if skid is valid, else from input. If main empties with no source, main_v clears.
- flush: clears main_v and skid_v at the edge. A transaction accepted in the same cycle is discarded. Data registers keep stale values. The flush cycle itself still counts toward stall_cnt if the stall condition held.
- rst: priority over flush. Clears main_v, skid_v, main_ctrl, main_data and stall_cnt to 0.
- stall_cnt: increments each cycle with out_valid && !out_ready. It saturates at 2^CNT_W-1 with no wrap, and only rst clears it.

## Timing
- Latency: input accepted at edge N appears on out_* after edge N (one cycle), assuming main is free.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0. in_ready=1 in the cycle after reset.
- Full throughput: with in_valid=out_ready=1 continuously, one transaction per cycle.
- Simultaneous accept and deliver with main full: the new transaction replaces main at the same edge.
- in_ready behaviour depends on PIPE_SKID_EN (see Configuration).

## Configuration
- PIPE_SKID_EN defined:
  - Adds a one-entry skid register (skid_v, skid_ctrl, skid_data).
  - in_ready = !skid_v, a registered signal with no combinational path from out_ready.
  - An input accepted while main is full and not being delivered goes to skid.
  - When main is delivered and skid_v=1, skid moves to main and skid_v clears.
  - Capacity is 2. Once skid is full, in_ready drops on the next cycle.
- PIPE_SKID_EN undefined:
  - No skid storage; capacity is 1.
  - in_ready = !main_v || out_ready, combinational from out_ready.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_ctrl=4'hF -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0; in_ready=1 after release.
- Streaming: out_ready=1, feed data 1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles, each one cycle later, with no gaps.
- Backpressure: load A, drop out_ready for 3 cycles while offering B, C. Required response:
  - Skid build: A held, B in skid, in_ready=0; C accepted only after A delivers; order A, B, C.
  - Non-skid build: in_ready=0 until A delivers.
  - Both builds: stall_cnt=3.
- Flush: main holding ctrl=4'b1101, assert flush with in_valid=1 carrying D -> next cycle out_valid=0, out_ctrl=0, D never appears.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt reaches 15 and holds; flush does not clear it; rst does.
- Bubble gating: in_valid=0 with in_ctrl=4'hF -> out_ctrl stays 0 and out_valid stays 0.
